multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath: one shared ALU, one unified instruction/data memory, and IR, A, B, ALUOut and MDR holding registers.
- Sequences each instruction over 3–5 cycles by driving mux selects, ALU operation and write enables.
- Instruction set: add, addi, lw, sw, bgtz, j.
- Sits beside the datapath and takes opcode/funct from the IR.

Parameters:
- none (encodings are fixed by the datapath)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- branch_cond  in  1  datapath flag: register A is signed > 0
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR load enable
- RegDst  out  1  register write address: 0 = rt, 1 = rd
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- ALUControl  out  3  001 = add, 010 = sub
- PCSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load enable = PCWrite | (Branch & branch_cond)
- instr_done  out  1  high on the final cycle of each instruction
- state  out  4  current state, for debug

Behaviour:
- State register: 4 bits. Every output is a combinational decode of the state; outputs not listed for a state are 0.
- Opcode register op_q: captured only in DECODE; all later branching uses op_q.
- States, with asserted outputs and next state:
  - IDLE (0): entered on rst; all outputs 0; next FETCH.
  - FETCH (1): IorD=0, IRWrite, ALUSrcA=0, ALUSrcB=01, ALUControl=001, PCSrc=00, PCWrite; next DECODE.
  - DECODE (2): ALUSrcA=0, ALUSrcB=11, ALUControl=001 (branch target into ALUOut). Next state by opcode:
    - 0x23 or 0x2b -> MEMADR
    - 0x00 with funct 0x20 -> EXEC
    - 0x08 -> ADDIEX
    - 0x07 -> BRANCH
    - 0x02 -> JUMP
    - anything else -> illegal handling (see Optional Feature)
  - MEMADR (3): ALUSrcA=1, ALUSrcB=10, ALUControl=001; next MEMRD if op_q=0x23, else MEMWR.
  - MEMRD (4): IorD=1; next MEMWB.
  - MEMWB (5): RegDst=0, MemtoReg=1, RegWrite, instr_done; next FETCH.
  - MEMWR (6): IorD=1, MemWrite, instr_done; next FETCH.
  - EXEC (7): ALUSrcA=1, ALUSrcB=00, ALUControl=001; next ALUWB.
  - ALUWB (8): RegDst=1, MemtoReg=0, RegWrite, instr_done; next FETCH.
  - ADDIEX (9): ALUSrcA=1, ALUSrcB=10, ALUControl=001; next ADDIWB.
  - ADDIWB (10): RegDst=0, MemtoReg=0, RegWrite, instr_done; next FETCH.
  - BRANCH (11): ALUSrcA=1, ALUSrcB=00, ALUControl=010, Branch, PCSrc=01, instr_done; pc_en = branch_cond; next FETCH.
  - JUMP (12): PCSrc=10, PCWrite, instr_done; next FETCH.
  - HALT (13): see Optional Feature.
  - Codes 14–15: unreachable; decode as IDLE, next FETCH.
- Cycles per instruction: lw 5, sw/add/addi 4, bgtz/j 3.
- pc_en is high only in FETCH, JUMP, and BRANCH with branch_cond=1.
- At most one of RegWrite/MemWrite/IRWrite is high in any cycle.
- rst sampled high in any state: next state IDLE, op_q cleared. No write enable is asserted in the cycle after the reset edge.
- Inputs are ignored outside DECODE. opcode/funct changing mid-instruction has no effect.
- branch_cond is read only in BRANCH.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode, or opcode 0 with funct≠0x20, in DECODE -> HALT.
  - HALT: all outputs 0 except `halted`=1 (extra 1-bit output port). Stays in HALT until rst.
- Undefined:
  - Such an instruction is a NOP: instr_done is asserted in DECODE and the next state is FETCH (2-cycle instruction).
  - No `halted` port, and no HALT state.

Test Plan:
- Reset: rst high 2 cycles, release -> state=0 with all outputs 0 for one cycle, then FETCH with IRWrite=1, pc_en=1, ALUSrcB=01.
- lw (op 0x23) -> states 1,2,3,4,5. In state 4, IorD=1. In state 5, RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next cycle FETCH.
- sw (0x2b) then add (0x00/0x20) -> sw: 1,2,3,6 with MemWrite=1 only in 6. add: 1,2,7,8 with RegDst=1, RegWrite=1 in 8.
- bgtz (0x07):
  - branch_cond=1 -> in state 11, pc_en=1, PCSrc=01, ALUControl=010.
  - Repeat with branch_cond=0 -> pc_en=0.
  - Both cases return to FETCH after 3 cycles.
- j (0x02) and addi (0x08):
  - j: 1,2,12 with PCSrc=10, pc_en=1.
  - addi: 1,2,9,10 with ALUSrcB=10 in 9 and RegWrite=1, RegDst=0 in 10.
  - opcode toggled to 0x2b during state 9 -> no change in sequence.
- Illegal opcode 0x3f:
  - with ILLEGAL_TRAP_EN -> HALT with halted=1, held for 10 cycles; rst -> IDLE.
  - without -> 1,2,1 with instr_done=1 in DECODE.
  - rst asserted during MEMRD -> IDLE next cycle, MemWrite/RegWrite stay 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (add, addi, lw, sw, bgtz, j).
// Define ILLEGAL_TRAP_EN to trap illegal instructions in a HALT state; otherwise they execute as NOPs.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       branch_cond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       pc_en,
  output logic       instr_done,
`ifdef ILLEGAL_TRAP_EN
  output logic       halted,
`endif
  output logic [3:0] state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] S_HALT   = 4'd13;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_ADD   = 6'h20;

  logic [3:0] state_next;
  logic [5:0] op_q;
  logic       legal;
  logic       pc_write;
  logic       branch;

  assign legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_ADDI) ||
                 (opcode == OP_BGTZ) || (opcode == OP_J) ||
                 ((opcode == OP_RTYPE) && (funct == FN_ADD));

  // State register; op_q freezes the opcode seen in DECODE for the rest of the instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= 6'h00;
    end else begin
      state <= state_next;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW))            state_next = S_MEMADR;
        else if ((opcode == OP_RTYPE) && (funct == FN_ADD))    state_next = S_EXEC;
        else if (opcode == OP_ADDI)                            state_next = S_ADDIEX;
        else if (opcode == OP_BGTZ)                            state_next = S_BRANCH;
        else if (opcode == OP_J)                               state_next = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
        else                                                   state_next = S_HALT;
`else
        else                                                   state_next = S_FETCH;
`endif
      end
      S_MEMADR: state_next = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:   state_next = S_HALT;
`endif
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    PCSrc      = 2'b00;
    instr_done = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    halted     = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = 3'b001;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = 3'b001;
`ifndef ILLEGAL_TRAP_EN
        instr_done = ~legal;
`endif
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = 3'b001;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b001;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b010;
        branch     = 1'b1;
        PCSrc      = 2'b01;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: halted = 1'b1;
`endif
      default: ;
    endcase
    pc_en = pc_write | (branch & branch_cond);
  end

endmodule
